// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NREQ byte sources.
// Latches the winning byte, holds tx_start, then follows tx_on through one frame.
module uart_tx_arbiter #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned DBITS      = 8,
  parameter int unsigned START_HOLD = 5,
  parameter int unsigned ON_TIMEOUT = 2170
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DBITS-1:0]     req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic [DBITS-1:0]          tx_data,
  output logic                      tx_start,
  input  logic                      tx_on,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout_err
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned HW  = $clog2(START_HOLD + 1);
  localparam int unsigned TW  = $clog2(ON_TIMEOUT + 1);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(START_HOLD - 1);
  localparam logic [TW-1:0]  TO_LAST   = TW'(ON_TIMEOUT - 1);
  localparam logic [IDW-1:0] LAST_RST  = IDW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_ON, WAIT_OFF} state_t;

  state_t           state_q;
  logic [DBITS-1:0] tx_data_q;
  logic             tx_start_q;
  logic [IDW-1:0]   grant_q;
  logic [IDW-1:0]   last_q;
  logic [HW-1:0]    hold_q;
  logic             seen_q;
  logic [TW-1:0]    to_q;
  logic             done_q;
  logic             terr_q;

  logic [NREQ-1:0]  upper_mask;
  logic [NREQ-1:0]  upper_req;
  logic [NREQ-1:0]  pick_vec;
  logic [IDW-1:0]   winner;
  logic [DBITS-1:0] req_bytes [NREQ];
  logic             accept;

  // Requests above the last grant take precedence; if none, wrap to the lowest index.
  always_comb begin
    upper_mask = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      upper_mask[i] = (i > 32'(last_q));
    end
    upper_req = req_valid & upper_mask;
    pick_vec  = (upper_req != '0) ? upper_req : req_valid;
    winner    = '0;
    for (int unsigned i = NREQ; i > 0; i--) begin
      if (pick_vec[i-1]) winner = IDW'(i - 1);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_bytes[i] = req_data[i*DBITS +: DBITS];
    end
  end

  assign accept    = (state_q == IDLE) && !tx_on && (req_valid != '0);
  assign req_ready = accept ? (NREQ'(1) << winner) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      grant_q    <= '0;
      last_q     <= LAST_RST;
      hold_q     <= '0;
      seen_q     <= 1'b0;
      to_q       <= '0;
      done_q     <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      terr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            tx_data_q  <= req_bytes[winner];
            grant_q    <= winner;
            last_q     <= winner;
            tx_start_q <= 1'b1;
            hold_q     <= '0;
            seen_q     <= 1'b0;
            state_q    <= START;
          end
        end
        START: begin
          seen_q <= seen_q | tx_on;
          if (hold_q == HOLD_LAST) begin
            tx_start_q <= 1'b0;
            to_q       <= '0;
            state_q    <= (seen_q || tx_on) ? WAIT_OFF : WAIT_ON;
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        WAIT_ON: begin
          if (tx_on) begin
            state_q <= WAIT_OFF;
          end else if (to_q == TO_LAST) begin
            terr_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            to_q <= to_q + TW'(1);
          end
        end
        WAIT_OFF: begin
          if (!tx_on) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vector table, corner sequences and random
// traffic checked against a frame-level reference model and a UART stub.
module tb_uart_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int DBITS = 8;
  localparam int H     = 5;
  localparam int TO    = 2170;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DBITS-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic [DBITS-1:0]      tx_data;
  logic                  tx_start;
  logic                  tx_on;
  logic [1:0]            grant_id;
  logic                  busy, done, timeout_err;

  uart_tx_arbiter #(
    .NREQ(NREQ), .DBITS(DBITS), .START_HOLD(H), .ON_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start), .tx_on(tx_on),
    .grant_id(grant_id), .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // UART stub: responds to a tx_start rise after on_delay cycles, busy for on_len+1 cycles.
  logic       force_on, uart_on, uart_en, ts_prev;
  int         on_delay, on_len, u_cnt, u_ph, rx_cnt;
  logic [7:0] u_byte, rx_last;
  logic [7:0] sb_q[$];

  assign tx_on = force_on | uart_on;

  always @(posedge clk) begin
    ts_prev <= tx_start;
    if (rst) begin
      u_ph <= 0; u_cnt <= 0; uart_on <= 1'b0;
    end else begin
      case (u_ph)
        0: if (tx_start && !ts_prev && uart_en) begin
             u_byte <= tx_data; u_cnt <= on_delay; u_ph <= 1;
           end
        1: if (u_cnt == 0) begin
             uart_on <= 1'b1; u_cnt <= on_len; u_ph <= 2;
           end else u_cnt <= u_cnt - 1;
        default: if (u_cnt == 0) begin
             uart_on <= 1'b0; u_ph <= 0;
             rx_cnt  <= rx_cnt + 1; rx_last <= u_byte;
             if (sb_q.size() == 0) chk("rx_unexpected", 32'd0, 32'd1);
             else chk("rx_byte", u_byte, sb_q.pop_front());
           end else u_cnt <= u_cnt - 1;
      endcase
    end
  end

  // Reference model: frame expectations as functions of cycle index k since grant
  // and r, the first cycle tx_on was seen high.
  logic       mon_en;
  bit         m_act, m_prev;
  int         m_k, m_r, m_last, m_gid;
  logic [7:0] m_byte;

  always @(negedge clk) begin
    int k, lo, w, idx;
    bit e_done, e_terr, fin, idle_now, found;
    logic [NREQ-1:0] exp_rdy;
    if (!mon_en) begin
      m_act <= 0; m_k <= 0; m_r <= 0; m_prev <= 0;
      m_last <= NREQ - 1; m_gid <= 0; m_byte <= '0;
      sb_q.delete();
    end else begin
      e_done = 0; e_terr = 0; k = 0;
      if (m_act) begin
        k      = m_k + 1;
        lo     = (m_r + 1 > H + 1) ? m_r + 1 : H + 1;
        e_done = (m_r != 0) && (k - 1 >= lo) && !m_prev;
        e_terr = (m_r == 0) && (k == H + 1 + TO);
      end
      fin      = e_done || e_terr;
      idle_now = !m_act || fin;
      chk("busy", busy, !idle_now);
      chk("tx_start", tx_start, m_act && (k <= H));
      chk("done", done, e_done);
      chk("timeout_err", timeout_err, e_terr);
      chk("grant_id", grant_id, m_gid);
      chk("tx_data", tx_data, m_byte);
      if (m_act) begin
        if (fin) begin
          m_act <= 0;
          if (e_terr && sb_q.size() > 0) void'(sb_q.pop_front());
        end else begin
          m_k <= k;
          if (tx_on && m_r == 0) m_r <= k;
          m_prev <= tx_on;
        end
      end
      exp_rdy = '0; found = 0; w = 0;
      if (idle_now && !tx_on) begin
        for (int j = 1; j <= NREQ; j++) begin
          idx = (m_last + j) % NREQ;
          if (!found && req_valid[idx]) begin found = 1; w = idx; end
        end
      end
      if (found) exp_rdy[w] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      if (found) begin
        m_act <= 1; m_k <= 0; m_r <= 0; m_prev <= 0;
        m_last <= w; m_gid <= w;
        m_byte <= req_data[w*DBITS +: DBITS];
        sb_q.push_back(req_data[w*DBITS +: DBITS]);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; mon_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_done", done, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_ready", req_ready, 0);
    #1 mon_en = 1'b1;
  endtask

  task automatic wait_ready(input string name, input logic [NREQ-1:0] exp);
    int n = 0;
    do begin @(negedge clk); n++; end while (req_ready == '0 && n < 100);
    chk(name, req_ready, exp);
  endtask

  task automatic wait_done(input string name, input int maxc);
    int n = 0;
    do begin @(negedge clk); n++; end while (!done && n < maxc);
    chk(name, done, 1);
  endtask

  typedef struct {
    bit              do_rst;
    logic [NREQ-1:0] mask;
    logic [7:0]      base;
    int unsigned     exp_id;
    logic [7:0]      exp_byte;
  } vec_t;

  vec_t tv[12];
  logic [NREQ-1:0] acc;
  int hc, cnt, rx0;
  bit saw_done;

  initial begin
    rst = 1'b1; mon_en = 1'b0; req_valid = '0; req_data = '0;
    force_on = 1'b0; uart_en = 1'b1; on_delay = 2; on_len = 6; rx_cnt = 0; rx_last = '0;

    tv[0]  = '{1'b1, 4'b0001, 8'h55, 0, 8'h55};
    tv[1]  = '{1'b1, 4'b1111, 8'hA0, 0, 8'hA0};
    tv[2]  = '{1'b0, 4'b1111, 8'hA0, 1, 8'hA1};
    tv[3]  = '{1'b0, 4'b1111, 8'hA0, 2, 8'hA2};
    tv[4]  = '{1'b0, 4'b1111, 8'hA0, 3, 8'hA3};
    tv[5]  = '{1'b0, 4'b1111, 8'hA0, 0, 8'hA0};
    tv[6]  = '{1'b0, 4'b0100, 8'hF0, 2, 8'hF2};
    tv[7]  = '{1'b0, 4'b1010, 8'h30, 3, 8'h33};
    tv[8]  = '{1'b0, 4'b1010, 8'h30, 1, 8'h31};
    tv[9]  = '{1'b0, 4'b0011, 8'h40, 0, 8'h40};
    tv[10] = '{1'b0, 4'b1001, 8'h50, 3, 8'h53};
    tv[11] = '{1'b0, 4'b1001, 8'h50, 0, 8'h50};

    do_reset();

    for (int t = 0; t < 12; t++) begin
      if (tv[t].do_rst) do_reset();
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) req_data[i*DBITS +: DBITS] = tv[t].base + 8'(i);
      req_valid = tv[t].mask;
      wait_ready("tbl_ready", NREQ'(1) << tv[t].exp_id);
      @(posedge clk); #1 req_valid = '0;
      @(negedge clk);
      chk("tbl_byte", tx_data, tv[t].exp_byte);
      chk("tbl_gid", grant_id, tv[t].exp_id);
      wait_done("tbl_done", 200);
    end

    // Single requester served back-to-back with one idle cycle in between.
    @(posedge clk); #1;
    req_data[2*DBITS +: DBITS] = 8'hFF; req_valid = 4'b0100;
    wait_ready("b2b_ready1", 4'b0100);
    @(posedge clk); #1 req_data[2*DBITS +: DBITS] = 8'h00;
    @(negedge clk); chk("b2b_byte1", tx_data, 8'hFF);
    wait_done("b2b_done1", 200);
    chk("b2b_idle_start", tx_start, 0);
    chk("b2b_ready2", req_ready, 4'b0100);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    chk("b2b_rise", tx_start, 1);
    chk("b2b_gid2", grant_id, 2);
    chk("b2b_byte2", tx_data, 8'h00);
    wait_done("b2b_done2", 200);

    // Foreign busy in IDLE blocks the grant until released.
    @(posedge clk); #1;
    force_on = 1'b1; req_data[1*DBITS +: DBITS] = 8'h77; req_valid = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); chk("force_ready", req_ready, 0);
    end
    @(posedge clk); #1 force_on = 1'b0;
    @(negedge clk); chk("release_ready", req_ready, 4'b0010);
    @(posedge clk); #1 req_valid = '0;
    wait_done("force_done", 200);

    // UART never answers: timeout after TO cycles, no done.
    @(posedge clk); #1;
    uart_en = 1'b0; req_data[0 +: DBITS] = 8'h01; req_valid = 4'b0001;
    wait_ready("to_ready", 4'b0001);
    @(posedge clk); #1 req_valid = '0;
    hc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!tx_start) break;
      hc++;
    end
    chk("to_hold", hc, H);
    cnt = 0; saw_done = 0;
    while (!timeout_err && cnt < 3000) begin
      @(negedge clk); cnt++;
      if (done) saw_done = 1;
    end
    chk("to_cycles", cnt, TO);
    chk("to_no_done", saw_done, 0);
    chk("to_idle", busy, 0);
    uart_en = 1'b1;

    // Reset in the third START cycle aborts the frame.
    @(posedge clk); #1;
    req_data[1*DBITS +: DBITS] = 8'h33; req_valid = 4'b0010;
    wait_ready("mid_ready", 4'b0010);
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1; mon_en = 1'b0;
    @(negedge clk); chk("mid_pre_start", tx_start, 1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_start", tx_start, 0);
    chk("mid_busy", busy, 0);
    chk("mid_gid", grant_id, 0);
    #1 mon_en = 1'b1;
    rx0 = rx_cnt;
    @(posedge clk); #1;
    req_data[3*DBITS +: DBITS] = 8'h08; req_valid = 4'b1000;
    wait_ready("mid_ready3", 4'b1000);
    @(posedge clk); #1 req_valid = '0;
    wait_done("mid_done3", 200);
    @(negedge clk);
    chk("mid_rx_cnt", rx_cnt - rx0, 1);
    chk("mid_rx_byte", rx_last, 8'h08);

    // Random traffic under the reference model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); acc = req_ready;
      @(posedge clk); #1;
      on_delay = $urandom_range(0, 12);
      on_len   = $urandom_range(1, 10);
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        else if (req_valid[i]) begin
          if ($urandom_range(0, 39) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          req_data[i*DBITS +: DBITS] = 8'($urandom);
        end
      end
    end
    req_valid = '0;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while ((busy || uart_on) && cnt < 200);
    chk("drain_idle", busy, 0);
    chk("drain_sb", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
